// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified fetch/data SRAM arbiter.
// Owner codes tag which requester an in-flight read belongs to.
package mem_arb_pkg;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_IF   = 2'd1;
    localparam logic [1:0] OWN_DATA = 2'd2;

    localparam int DEF_STARVE_LIMIT = 4;

endpackage

// File: rtl/rdata_hold.sv
// Read-data return path for one requester: shows the SRAM word while
// it is the response owner, and keeps that word afterwards.
module rdata_hold #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data
);

    logic [DATA_W-1:0] r_hold;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_hold <= '0;
        end else if (i_valid) begin
            r_hold <= i_data;
        end
    end

    assign o_data = i_valid ? i_data : r_hold;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port SRAM between instruction fetch and data port.
// Data wins contention; a starvation counter bounds fetch waiting time.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic [DATA_W/8-1:0] d_wen,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                sram_en,
    output logic [DATA_W/8-1:0] sram_wen,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic [DATA_W-1:0]   sram_wdata,
    input  logic [DATA_W-1:0]   sram_rdata
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] r_starve_cnt;
    logic [1:0]       r_resp_owner;
    logic             w_force_if;
    logic             w_if_gnt;
    logic             w_d_gnt;
    logic             w_d_read;

    assign w_force_if = (r_starve_cnt == LIMIT);
    assign w_if_gnt   = resetn & if_req & (~d_req | w_force_if);
    assign w_d_gnt    = resetn & d_req & ~w_if_gnt;
    assign w_d_read   = (d_wen == '0);

    assign if_gnt = w_if_gnt;
    assign d_gnt  = w_d_gnt;

    always_comb begin
        sram_en    = 1'b0;
        sram_wen   = '0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (w_if_gnt) begin
            sram_en   = 1'b1;
            sram_addr = if_addr;
        end else if (w_d_gnt) begin
            sram_en    = 1'b1;
            sram_wen   = d_wen;
            sram_addr  = d_addr;
            sram_wdata = d_wdata;
        end
    end

    // Counts contested cycles fetch has lost in a row.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_starve_cnt <= '0;
        end else if (w_if_gnt || !if_req) begin
            r_starve_cnt <= '0;
        end else if (w_d_gnt && !w_force_if) begin
            r_starve_cnt <= r_starve_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_resp_owner <= OWN_NONE;
        end else if (w_if_gnt) begin
            r_resp_owner <= OWN_IF;
        end else if (w_d_gnt && w_d_read) begin
            r_resp_owner <= OWN_DATA;
        end else begin
            r_resp_owner <= OWN_NONE;
        end
    end

    assign if_rvalid = (r_resp_owner == OWN_IF);
    assign d_rvalid  = (r_resp_owner == OWN_DATA);

    rdata_hold #(.DATA_W(DATA_W)) u_if_hold (
        .clk     (clk),
        .resetn  (resetn),
        .i_valid (if_rvalid),
        .i_data  (sram_rdata),
        .o_data  (if_rdata)
    );

    rdata_hold #(.DATA_W(DATA_W)) u_d_hold (
        .clk     (clk),
        .resetn  (resetn),
        .i_valid (d_rvalid),
        .i_data  (sram_rdata),
        .o_data  (d_rdata)
    );

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port synchronous SRAM (1-cycle read latency) between the CPU's instruction-fetch port and data port, so the core runs from a single unified memory. Data accesses normally win; a saturating starvation counter guarantees instruction fetch a slot after a bounded number of lost cycles. The block tracks which requester owns each in-flight read, routes the returned word to that requester with a valid pulse, and holds each requester's last read word stable until its next response.

## Interface
- ADDR_W, 32, address width of both requesters and SRAM
- DATA_W, 32, data width; byte enables are DATA_W/8 bits
- STARVE_LIMIT, 4, contested cycles instruction fetch may lose in a row before it is forced to win; legal range ≥1
- clk  in  1  single clock, all state updates on rising edge
- resetn  in  1  synchronous, active-low reset
- if_req  in  1  fetch read request
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  DATA_W  fetch read data, held until next if_rvalid
- d_req  in  1  data request
- d_wen  in  DATA_W/8  byte write enables; all-zero = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  data read valid (reads only, never for writes)
- d_rdata  out  DATA_W  data read data, held until next d_rvalid
- sram_en  out  1  SRAM enable
- sram_wen  out  DATA_W/8  SRAM byte write enables
- sram_addr  out  ADDR_W  SRAM address
- sram_wdata  out  DATA_W  SRAM write data
- sram_rdata  in  DATA_W  SRAM read data, valid the cycle after a read enable

## Operation
- Grant (combinational, same cycle): only one of if_gnt/d_gnt high; none while resetn=0.
  - Only one req: that requester granted.
  - Both req: d wins unless starve_cnt == STARVE_LIMIT, then if wins.
- SRAM mux: sram_en = if_gnt|d_gnt; address/wdata/wen from granted requester; if granted → sram_wen=0; nothing granted → sram_en=0, sram_wen=0, addr/wdata 0.
- starve_cnt (width clog2(STARVE_LIMIT+1)), per edge:
  - if_req & d_gnt → increment, saturating at STARVE_LIMIT.
  - if_gnt or !if_req → 0.
- Response tracker resp_owner ∈ {NONE, IF, DATA}: next = IF on if_gnt; DATA on d_gnt with d_wen==0; otherwise NONE (data writes produce no response).
- Response cycle: resp_owner==IF → if_rvalid=1, if_rdata=sram_rdata; DATA → d_rvalid/d_rdata likewise. Non-owner's rdata shows its hold register.
- Hold registers: if_hold/d_hold load sram_rdata at end of the owner's response cycle; if_rdata/d_rdata = sram_rdata during own response, else hold value.
- Requesters may hold req high across cycles; each granted cycle is an independent access. Address/data must be valid while req is high.

## Timing
- Reset values (resetn low at an edge): starve_cnt 0, resp_owner NONE, both hold registers 0. During and after reset until first grant: all gnt 0, sram_en 0, sram_wen 0, both rvalid 0, both rdata 0.
- Read latency: grant in cycle N → rvalid in N+1, exactly one cycle.
- Throughput: one access per cycle, back-to-back grants (incl. alternating owners) with no bubble; response of N and grant of N+1 coexist.
- Write: granted in N, committed by SRAM at edge ending N; read of same address granted in N+1 returns new data in N+2.
- Reset mid-operation: read granted in cycle where resetn=0 is impossible; read granted in N with resetn low at edge ending N → no rvalid in N+1.
- Starvation bound: with both requesting continuously, fetch granted at least once every STARVE_LIMIT+1 cycles.

## Structure
- Shared package mem_arb_pkg: owner encoding localparams OWN_NONE=2'd0, OWN_IF=2'd1, OWN_DATA=2'd2; default STARVE_LIMIT.
- One natural sub-module: rdata_hold (response-valid gated capture register + bypass mux), instantiated twice (fetch, data). Grant logic, starve counter, resp tracker stay in the top.

## Test plan
- Fetch only: if_req=1, addr 0x00,0x04,0x08 consecutive cycles, SRAM holds 0x11,0x22,0x33 → if_gnt every cycle, if_rvalid cycles 1–3 with 0x11,0x22,0x33; if_rdata holds 0x33 afterwards.
- Data write then read: d_wen=4'hF addr 0x40 wdata 0xDEADBEEF, next cycle d_wen=0 addr 0x40 → no d_rvalid after write; d_rvalid one cycle after read with 0xDEADBEEF.
- Contention, STARVE_LIMIT=4: both req held high 10 cycles → grants D,D,D,D,I,D,D,D,D,I; starve_cnt 0,1,2,3,4,0,…
- Interleaved responses: d read 0x10 (=0xAA) then fetch 0x20 (=0xBB) back-to-back → d_rvalid/0xAA then if_rvalid/0xBB; d_rdata stays 0xAA during fetch response.
- Reset mid-read: fetch granted cycle N, resetn=0 at edge ending N → if_rvalid=0 in N+1; all outputs at reset values; starve_cnt 0.
- Partial write: d_wen=4'b0011 to address preloaded 0x12345678 with wdata 0xFFFFAAAA, then read → 0x1234AAAA.
